as_lut_arbiter: RTL and testbench
=================================

# as_lut_arbiter

Arbiter and maintenance sequencer for the anti-spoof MAC/IP CAM LUT's direct-access read and write ports. It shares those ports between the host register interface and an internal scrub engine. The scrub engine periodically walks the table and invalidates every non-protected learned entry, so stale MAC/IP/port bindings age out. It sits between the register block and `as_mac_cam_lut`; the lookup/learn port is not touched.

## Interface
Parameters:
- NUM_OUTPUT_QUEUES, 8, width of oq fields
- LUT_DEPTH_BITS, 4, table address width; LUT_DEPTH = 2**LUT_DEPTH_BITS
- SCRUB_PERIOD, 32'd125000000, cycles between automatic sweeps (≥ 2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- host_rd_req / host_rd_addr  in  1 / LUT_DEPTH_BITS  host read request (level, held until ack)
- host_rd_ack  out  1  one-cycle pulse; host_rd_oq, host_rd_wr_protect, host_rd_mac (NUM_OUTPUT_QUEUES/1/48) are valid in that cycle
- host_wr_req / host_wr_addr / host_wr_oq / host_wr_protect / host_wr_mac  in  1/LUT_DEPTH_BITS/NUM_OUTPUT_QUEUES/1/48  host write request (held until ack)
- host_wr_ack  out  1  one-cycle pulse
- scrub_en  in  1  enables the periodic timer
- scrub_now  in  1  pulse; starts a sweep at the next IDLE
- scrub_busy  out  1  high while a sweep is in progress
- scrub_cleared  out  16  saturating count of entries invalidated since reset
- rd_addr, rd_req, wr_addr, wr_req, wr_oq, wr_protect, wr_mac  out  —  to the LUT direct-access ports
- rd_ack, rd_oq, rd_wr_protect, rd_mac, wr_ack  in  —  from the LUT

## Operation
- States: IDLE, HOST_RD, HOST_WR, SCR_RD, SCR_WR, SCR_NEXT.
- IDLE priority: host write > host read > scrub step, when `scrub_pending` is set.
- `scrub_pending` is set by `scrub_now`, or by the period counter reaching SCRUB_PERIOD-1 while scrub_en=1. The counter then reloads to 0 and counts only while scrub_en=1.
- Sweep start: scrub_addr ← 0, scrub_busy ← 1.
- One sweep step is SCR_RD then SCR_WR, and is atomic. No host request is granted between the read and the write of the same address.
- Host requests are granted only in IDLE, which is between scrub steps.
- SCR_RD: issue read of scrub_addr. On rd_ack:
  - if rd_wr_protect=0 and rd_oq≠0, go to SCR_WR;
  - otherwise go to SCR_NEXT.
- SCR_WR: write {protect=0, oq=0, mac=0} to scrub_addr. On wr_ack, increment scrub_cleared (saturating at 16'hFFFF), then go to SCR_NEXT.
- SCR_NEXT:
  - if scrub_addr = LUT_DEPTH-2, clear scrub_pending and scrub_busy; the broadcast entry at LUT_DEPTH-1 is never touched.
  - otherwise increment scrub_addr.
  - Return to IDLE in both cases.
- HOST_RD / HOST_WR: forward the address and data to the LUT. Pass the ack and read data straight through to the host in the ack cycle, then return to IDLE.
- A scrub_now or timer event during a sweep sets scrub_pending again. A second sweep then runs back-to-back.

## Timing
- Reset: all outputs 0, state IDLE, counters 0, scrub_pending 0.
- Reset applied mid-transaction aborts the transaction immediately. Nothing is retried.
- rd_req = pending_rd & ~rd_ack, and wr_req = pending_wr & ~wr_ack.
  - Each request is asserted from the cycle after entering the state, and held through any LUT stall (CAM busy, LUT init).
  - It is dropped combinationally in the ack cycle, so the LUT never accepts a request twice.
- Address and write-data outputs are registered and stable for the whole request.
- Minimum host read latency is 2 cycles from host_rd_req to host_rd_ack (grant cycle, then LUT ack). A pending scrub step adds up to one SCR_RD/SCR_WR pair.
- The host ack is combinational from the LUT ack. Host request signals are sampled only at the grant.
- A sweep with no clears takes at least 3·(LUT_DEPTH-1) cycles.

## Structure
- Shared package `as_lut_pkg`: state encodings, the invalidated-entry constant {1'b0, oq 0, mac 0}, and the LUT_DEPTH_BITS default.
- Sub-module `as_scrub_timer`: period counter plus pending flag, with inputs scrub_en and scrub_now and a clear input driven at end of sweep.
- Arbiter FSM and datapath stay in the top level.

## Test plan
- Host write addr 3 (oq=8'h04, protect=0, mac=48'h0011_2233_4455), then read addr 3 → host_wr_ack then host_rd_ack, returned data equal to what was written. The LUT sees exactly one wr_req acceptance and one rd_req acceptance.
- Entries 1 and 2 learned, entry 5 written with protect=1; pulse scrub_now → entries 1 and 2 read back all-zero, entry 5 unchanged, entry 15 (broadcast) never addressed, scrub_cleared=2, scrub_busy low after the last step.
- Host write asserted while the scrub is in SCR_RD of addr 4 → the host write is granted only after the SCR_WR/SCR_NEXT for addr 4. No write to addr 4 occurs between the scrub read and the scrub write.
- LUT holds the acks off for 16 cycles (CAM busy) → rd_req/wr_req stay high with stable address for all 16 cycles, then drop in the ack cycle.
- SCRUB_PERIOD=100, scrub_en=1 → a sweep starts at cycle 100 and again at cycle 200. Clearing scrub_en at cycle 150 prevents the second sweep.
- Reset asserted during SCR_WR → all outputs 0 immediately. After release, state is IDLE, scrub_cleared=0, and no request is pending.

Source files
------------

// File: rtl/as_lut_pkg.sv
// rtl/as_lut_pkg.sv - shared states and constants for the CAM LUT arbiter and scrubber
package as_lut_pkg;

    localparam int LUT_DEPTH_BITS_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOST_RD,
        ST_HOST_WR,
        ST_SCR_RD,
        ST_SCR_WR,
        ST_SCR_NEXT
    } arb_state_e;

    // Invalidated entry: unprotected, no output queues, zero MAC (oq is zero-filled at use)
    localparam logic        INV_PROTECT = 1'b0;
    localparam logic [47:0] INV_MAC     = 48'h0;

endpackage

// File: rtl/as_scrub_timer.sv
// rtl/as_scrub_timer.sv - sweep period counter and pending-sweep flag
module as_scrub_timer #(
    parameter logic [31:0] SCRUB_PERIOD = 32'd125000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scrub_en_i,
    input  logic scrub_now_i,
    input  logic busy_i,
    input  logic clr_i,
    output logic pending_o
);

    logic [31:0] cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic        rearm_q, rearm_d;
    logic        tick;
    logic        req_event;

    assign tick      = scrub_en_i && (cnt_q == SCRUB_PERIOD - 32'd1);
    assign req_event = scrub_now_i | tick;
    assign pending_o = pending_q;

    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        rearm_d   = rearm_q;
        if (scrub_en_i) begin
            cnt_d = tick ? 32'd0 : cnt_q + 32'd1;
        end
        // A request seen during a sweep survives the end-of-sweep clear
        if (clr_i) begin
            pending_d = rearm_q | req_event;
            rearm_d   = 1'b0;
        end else begin
            pending_d = pending_q | req_event;
            rearm_d   = rearm_q | (req_event & busy_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= 32'd0;
            pending_q <= 1'b0;
            rearm_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            rearm_q   <= rearm_d;
        end
    end

endmodule

// File: rtl/as_lut_arbiter.sv
// rtl/as_lut_arbiter.sv - shares the LUT direct-access ports between host and scrub engine
module as_lut_arbiter
    import as_lut_pkg::*;
#(
    parameter int          NUM_OUTPUT_QUEUES = 8,
    parameter int          LUT_DEPTH_BITS    = LUT_DEPTH_BITS_DEF,
    parameter logic [31:0] SCRUB_PERIOD      = 32'd125000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         host_rd_req,
    input  logic [LUT_DEPTH_BITS-1:0]    host_rd_addr,
    output logic                         host_rd_ack,
    output logic [NUM_OUTPUT_QUEUES-1:0] host_rd_oq,
    output logic                         host_rd_wr_protect,
    output logic [47:0]                  host_rd_mac,
    input  logic                         host_wr_req,
    input  logic [LUT_DEPTH_BITS-1:0]    host_wr_addr,
    input  logic [NUM_OUTPUT_QUEUES-1:0] host_wr_oq,
    input  logic                         host_wr_protect,
    input  logic [47:0]                  host_wr_mac,
    output logic                         host_wr_ack,
    input  logic                         scrub_en,
    input  logic                         scrub_now,
    output logic                         scrub_busy,
    output logic [15:0]                  scrub_cleared,
    output logic [LUT_DEPTH_BITS-1:0]    rd_addr,
    output logic                         rd_req,
    output logic [LUT_DEPTH_BITS-1:0]    wr_addr,
    output logic                         wr_req,
    output logic [NUM_OUTPUT_QUEUES-1:0] wr_oq,
    output logic                         wr_protect,
    output logic [47:0]                  wr_mac,
    input  logic                         rd_ack,
    input  logic [NUM_OUTPUT_QUEUES-1:0] rd_oq,
    input  logic                         rd_wr_protect,
    input  logic [47:0]                  rd_mac,
    input  logic                         wr_ack
);

    localparam int LUT_DEPTH = 2 ** LUT_DEPTH_BITS;
    localparam logic [LUT_DEPTH_BITS-1:0] LAST_ADDR = LUT_DEPTH_BITS'(LUT_DEPTH - 2);

    arb_state_e                   state_q, state_d;
    logic [LUT_DEPTH_BITS-1:0]    scrub_addr_q, scrub_addr_d;
    logic                         busy_q, busy_d;
    logic [15:0]                  cleared_q, cleared_d;
    logic [LUT_DEPTH_BITS-1:0]    rd_addr_q, rd_addr_d;
    logic [LUT_DEPTH_BITS-1:0]    wr_addr_q, wr_addr_d;
    logic [NUM_OUTPUT_QUEUES-1:0] wr_oq_q, wr_oq_d;
    logic                         wr_protect_q, wr_protect_d;
    logic [47:0]                  wr_mac_q, wr_mac_d;
    logic                         scrub_pending;
    logic                         sweep_done;
    logic                         pending_rd, pending_wr;

    as_scrub_timer #(
        .SCRUB_PERIOD(SCRUB_PERIOD)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (reset),
        .scrub_en_i (scrub_en),
        .scrub_now_i(scrub_now),
        .busy_i     (busy_q),
        .clr_i      (sweep_done),
        .pending_o  (scrub_pending)
    );

    always_comb begin
        state_d      = state_q;
        scrub_addr_d = scrub_addr_q;
        busy_d       = busy_q;
        cleared_d    = cleared_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        wr_oq_d      = wr_oq_q;
        wr_protect_d = wr_protect_q;
        wr_mac_d     = wr_mac_q;
        sweep_done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (host_wr_req) begin
                    wr_addr_d    = host_wr_addr;
                    wr_oq_d      = host_wr_oq;
                    wr_protect_d = host_wr_protect;
                    wr_mac_d     = host_wr_mac;
                    state_d      = ST_HOST_WR;
                end else if (host_rd_req) begin
                    rd_addr_d = host_rd_addr;
                    state_d   = ST_HOST_RD;
                end else if (scrub_pending) begin
                    state_d = ST_SCR_RD;
                    if (!busy_q) begin
                        scrub_addr_d = '0;
                        busy_d       = 1'b1;
                        rd_addr_d    = '0;
                    end else begin
                        rd_addr_d = scrub_addr_q;
                    end
                end
            end
            ST_HOST_RD: if (rd_ack) state_d = ST_IDLE;
            ST_HOST_WR: if (wr_ack) state_d = ST_IDLE;
            ST_SCR_RD: begin
                // Only unprotected entries that still own a queue are worth invalidating
                if (rd_ack) begin
                    if (!rd_wr_protect && (rd_oq != '0)) begin
                        wr_addr_d    = scrub_addr_q;
                        wr_oq_d      = '0;
                        wr_protect_d = INV_PROTECT;
                        wr_mac_d     = INV_MAC;
                        state_d      = ST_SCR_WR;
                    end else begin
                        state_d = ST_SCR_NEXT;
                    end
                end
            end
            ST_SCR_WR: begin
                if (wr_ack) begin
                    if (cleared_q != 16'hFFFF) cleared_d = cleared_q + 16'd1;
                    state_d = ST_SCR_NEXT;
                end
            end
            ST_SCR_NEXT: begin
                // The broadcast entry at the top of the table is never scrubbed
                if (scrub_addr_q == LAST_ADDR) begin
                    sweep_done = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    scrub_addr_d = scrub_addr_q + 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            scrub_addr_q <= '0;
            busy_q       <= 1'b0;
            cleared_q    <= 16'd0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            wr_oq_q      <= '0;
            wr_protect_q <= 1'b0;
            wr_mac_q     <= 48'h0;
        end else begin
            state_q      <= state_d;
            scrub_addr_q <= scrub_addr_d;
            busy_q       <= busy_d;
            cleared_q    <= cleared_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            wr_oq_q      <= wr_oq_d;
            wr_protect_q <= wr_protect_d;
            wr_mac_q     <= wr_mac_d;
        end
    end

    assign pending_rd = (state_q == ST_HOST_RD) || (state_q == ST_SCR_RD);
    assign pending_wr = (state_q == ST_HOST_WR) || (state_q == ST_SCR_WR);
    assign rd_req     = pending_rd & ~rd_ack;
    assign wr_req     = pending_wr & ~wr_ack;
    assign rd_addr    = rd_addr_q;
    assign wr_addr    = wr_addr_q;
    assign wr_oq      = wr_oq_q;
    assign wr_protect = wr_protect_q;
    assign wr_mac     = wr_mac_q;

    assign host_rd_ack        = (state_q == ST_HOST_RD) & rd_ack;
    assign host_wr_ack        = (state_q == ST_HOST_WR) & wr_ack;
    assign host_rd_oq         = host_rd_ack ? rd_oq : '0;
    assign host_rd_wr_protect = host_rd_ack & rd_wr_protect;
    assign host_rd_mac        = host_rd_ack ? rd_mac : 48'h0;

    assign scrub_busy    = busy_q;
    assign scrub_cleared = cleared_q;

endmodule

// File: tb/tb_as_lut_arbiter.sv
// tb/tb_as_lut_arbiter.sv - directed self-checking bench with a stalling LUT model
module tb_as_lut_arbiter;

    localparam int NOQ = 8;
    localparam int DB  = 4;

    typedef struct {
        logic [3:0]  addr;
        logic [7:0]  oq;
        logic        pr;
        logic [47:0] mac;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic           host_rd_req, host_wr_req, host_rd_ack, host_wr_ack;
    logic [DB-1:0]  host_rd_addr, host_wr_addr;
    logic [NOQ-1:0] host_rd_oq, host_wr_oq;
    logic           host_rd_wr_protect, host_wr_protect;
    logic [47:0]    host_rd_mac, host_wr_mac;
    logic           scrub_en, scrub_now, scrub_busy;
    logic [15:0]    scrub_cleared;
    logic [DB-1:0]  rd_addr, wr_addr;
    logic           rd_req, wr_req, wr_protect, rd_ack, wr_ack, rd_wr_protect;
    logic [NOQ-1:0] wr_oq, rd_oq;
    logic [47:0]    wr_mac, rd_mac;

    as_lut_arbiter #(
        .NUM_OUTPUT_QUEUES(NOQ),
        .LUT_DEPTH_BITS   (DB),
        .SCRUB_PERIOD     (32'd100)
    ) dut (
        .clk(clk), .reset(reset),
        .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr), .host_rd_ack(host_rd_ack),
        .host_rd_oq(host_rd_oq), .host_rd_wr_protect(host_rd_wr_protect), .host_rd_mac(host_rd_mac),
        .host_wr_req(host_wr_req), .host_wr_addr(host_wr_addr), .host_wr_oq(host_wr_oq),
        .host_wr_protect(host_wr_protect), .host_wr_mac(host_wr_mac), .host_wr_ack(host_wr_ack),
        .scrub_en(scrub_en), .scrub_now(scrub_now), .scrub_busy(scrub_busy),
        .scrub_cleared(scrub_cleared),
        .rd_addr(rd_addr), .rd_req(rd_req), .wr_addr(wr_addr), .wr_req(wr_req),
        .wr_oq(wr_oq), .wr_protect(wr_protect), .wr_mac(wr_mac),
        .rd_ack(rd_ack), .rd_oq(rd_oq), .rd_wr_protect(rd_wr_protect), .rd_mac(rd_mac),
        .wr_ack(wr_ack)
    );

    // LUT model: acks after a programmable number of stalled cycles
    logic [NOQ-1:0] mem_oq [16];
    logic           mem_pr [16];
    logic [47:0]    mem_mac[16];
    int rd_stall = 0, wr_stall = 0, rd_cnt = 0, wr_cnt = 0;
    int rd_acc = 0, wr_acc = 0, rd_samples = 0, wr_samples = 0, wr4_n = 0;
    logic [7:0] wr4_first = 8'h0;
    bit touched15 = 0, unstable = 0;
    logic [DB-1:0] rd_prev, wr_prev;

    always @(negedge clk) begin
        if (!reset) begin
            rd_ack = 0; wr_ack = 0; rd_cnt = 0; wr_cnt = 0;
            rd_oq = '0; rd_wr_protect = 0; rd_mac = '0;
        end else begin
            if ((rd_req && rd_addr == 4'hF) || (wr_req && wr_addr == 4'hF)) touched15 = 1;
            if (rd_ack) begin
                rd_ack = 0; rd_cnt = 0;
            end else if (rd_req) begin
                rd_samples++;
                if (rd_cnt > 0 && rd_addr != rd_prev) unstable = 1;
                rd_prev = rd_addr;
                if (rd_cnt >= rd_stall) begin
                    rd_ack = 1; rd_acc++;
                    rd_oq = mem_oq[rd_addr]; rd_wr_protect = mem_pr[rd_addr]; rd_mac = mem_mac[rd_addr];
                end else rd_cnt++;
            end
            if (wr_ack) begin
                wr_ack = 0; wr_cnt = 0;
            end else if (wr_req) begin
                wr_samples++;
                if (wr_cnt > 0 && wr_addr != wr_prev) unstable = 1;
                wr_prev = wr_addr;
                if (wr_cnt >= wr_stall) begin
                    wr_ack = 1; wr_acc++;
                    mem_oq[wr_addr] = wr_oq; mem_pr[wr_addr] = wr_protect; mem_mac[wr_addr] = wr_mac;
                    if (wr_addr == 4'd4) begin
                        wr4_n++;
                        if (wr4_n == 1) wr4_first = wr_oq;
                    end
                end else wr_cnt++;
            end
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 0; scrub_en = 0; scrub_now = 0; host_rd_req = 0; host_wr_req = 0;
        host_rd_addr = '0; host_wr_addr = '0; host_wr_oq = '0; host_wr_protect = 0; host_wr_mac = '0;
        rd_stall = 0; wr_stall = 0;
        for (int i = 0; i < 16; i++) begin mem_oq[i] = '0; mem_pr[i] = 0; mem_mac[i] = '0; end
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] oq, input logic pr,
                              input logic [47:0] mac, output bit ok);
        host_wr_addr = a; host_wr_oq = oq; host_wr_protect = pr; host_wr_mac = mac;
        host_wr_req = 1; ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (host_wr_ack) begin ok = 1; break; end
        end
        host_wr_req = 0;
    endtask

    task automatic host_read(input logic [3:0] a, output logic [7:0] oq, output logic pr,
                             output logic [47:0] mac, output bit ok);
        host_rd_addr = a; host_rd_req = 1; ok = 0; oq = 'x; pr = 'x; mac = 'x;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (host_rd_ack) begin
                ok = 1; oq = host_rd_oq; pr = host_rd_wr_protect; mac = host_rd_mac;
                break;
            end
        end
        host_rd_req = 0;
    endtask

    task automatic pulse_scrub();
        @(negedge clk); scrub_now = 1;
        @(negedge clk); scrub_now = 0;
    endtask

    task automatic wait_busy(input logic lvl, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #1;
            if (scrub_busy == lvl) begin ok = 1; break; end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1);
    end

    ent_t wr_vec[4];
    ent_t exp_vec[5];
    bit ok, ok2, any_req;
    logic [7:0] q_oq;
    logic q_pr;
    logic [47:0] q_mac;
    int a0, b0, r1, r2, nrise;
    logic prev_busy;

    initial begin
        wr_vec[0] = '{4'd1,  8'h02, 1'b0, 48'hAAAA_0000_0001};
        wr_vec[1] = '{4'd2,  8'h81, 1'b0, 48'hBBBB_0000_0002};
        wr_vec[2] = '{4'd5,  8'h10, 1'b1, 48'hCCCC_0000_0005};
        wr_vec[3] = '{4'd15, 8'hFF, 1'b0, 48'hFFFF_FFFF_FFFF};
        exp_vec[0] = '{4'd1,  8'h00, 1'b0, 48'h0};
        exp_vec[1] = '{4'd2,  8'h00, 1'b0, 48'h0};
        exp_vec[2] = '{4'd5,  8'h10, 1'b1, 48'hCCCC_0000_0005};
        exp_vec[3] = '{4'd15, 8'hFF, 1'b0, 48'hFFFF_FFFF_FFFF};
        exp_vec[4] = '{4'd0,  8'h00, 1'b0, 48'h0};

        // Reset state
        do_reset();
        chk("rst_rd_req", rd_req, 0);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_busy", scrub_busy, 0);
        chk("rst_cleared", scrub_cleared, 0);

        // Host write then read back
        a0 = wr_acc; b0 = rd_acc;
        host_write(4'd3, 8'h04, 1'b0, 48'h0011_2233_4455, ok);
        chk("t1_wr_ack", ok, 1);
        host_read(4'd3, q_oq, q_pr, q_mac, ok);
        chk("t1_rd_ack", ok, 1);
        chk("t1_rd_oq", q_oq, 8'h04);
        chk("t1_rd_pr", q_pr, 0);
        chk("t1_rd_mac", q_mac, 48'h0011_2233_4455);
        repeat (3) @(negedge clk);
        chk("t1_wr_accepts", wr_acc - a0, 1);
        chk("t1_rd_accepts", rd_acc - b0, 1);

        // Sweep clears learned entries, spares protected and broadcast
        do_reset();
        foreach (wr_vec[i]) begin
            host_write(wr_vec[i].addr, wr_vec[i].oq, wr_vec[i].pr, wr_vec[i].mac, ok);
            chk("t2_setup_wr", ok, 1);
        end
        touched15 = 0;
        pulse_scrub();
        wait_busy(1'b1, 10, ok);
        chk("t2_busy_rise", ok, 1);
        wait_busy(1'b0, 500, ok);
        chk("t2_busy_fall", ok, 1);
        chk("t2_cleared", scrub_cleared, 2);
        chk("t2_touched15", touched15, 0);
        foreach (exp_vec[i]) begin
            host_read(exp_vec[i].addr, q_oq, q_pr, q_mac, ok);
            chk("t2_rd_ack", ok, 1);
            chk("t2_oq", q_oq, exp_vec[i].oq);
            chk("t2_pr", q_pr, exp_vec[i].pr);
            chk("t2_mac", q_mac, exp_vec[i].mac);
        end

        // Host write arrives during the scrub read of addr 4
        host_write(4'd4, 8'h33, 1'b0, 48'h4444_0000_0044, ok);
        chk("t3_setup_wr", ok, 1);
        wr4_n = 0; rd_stall = 5;
        pulse_scrub();
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (rd_req && rd_addr == 4'd4 && scrub_busy) begin ok = 1; break; end
        end
        chk("t3_saw_scr_rd4", ok, 1);
        host_write(4'd4, 8'h0A, 1'b0, 48'h0A0A_0A0A_0A0A, ok);
        chk("t3_host_wr_ack", ok, 1);
        chk("t3_wr4_count", wr4_n, 2);
        chk("t3_wr4_first_oq", wr4_first, 8'h00);
        wait_busy(1'b0, 500, ok);
        chk("t3_busy_fall", ok, 1);
        rd_stall = 0;
        host_read(4'd4, q_oq, q_pr, q_mac, ok);
        chk("t3_rd4_oq", q_oq, 8'h0A);
        chk("t3_rd4_mac", q_mac, 48'h0A0A_0A0A_0A0A);
        chk("t3_cleared", scrub_cleared, 3);

        // LUT stalls both ports for 16 cycles
        rd_stall = 16; wr_stall = 16; unstable = 0; wr_samples = 0; rd_samples = 0;
        host_write(4'd7, 8'h5A, 1'b1, 48'h7777_0000_0077, ok);
        chk("t4_wr_ack", ok, 1);
        chk("t4_wr_req_drop", wr_req, 0);
        chk("t4_wr_req_cycles", wr_samples, 17);
        host_read(4'd7, q_oq, q_pr, q_mac, ok);
        chk("t4_rd_ack", ok, 1);
        chk("t4_rd_req_drop", rd_req, 0);
        chk("t4_rd_req_cycles", rd_samples, 17);
        chk("t4_rd_oq", q_oq, 8'h5A);
        chk("t4_rd_pr", q_pr, 1);
        chk("t4_addr_stable", unstable, 0);

        // Periodic timer: sweeps start 100 cycles apart
        do_reset();
        scrub_en = 1; r1 = -1; r2 = -1; prev_busy = 0;
        for (int c = 1; c <= 260; c++) begin
            @(negedge clk); #1;
            if (scrub_busy && !prev_busy) begin
                if (r1 < 0) r1 = c; else if (r2 < 0) r2 = c;
            end
            prev_busy = scrub_busy;
        end
        chk("t5_rise1_at_101", (r1 >= 100 && r1 <= 102), 1);
        chk("t5_rise2_at_201", (r2 >= 200 && r2 <= 202), 1);
        do_reset();
        scrub_en = 1; nrise = 0; prev_busy = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk); #1;
            if (c == 150) scrub_en = 0;
            if (scrub_busy && !prev_busy) nrise++;
            prev_busy = scrub_busy;
        end
        chk("t5_one_sweep_only", nrise, 1);

        // Reset asserted while the scrub write is stalled
        do_reset();
        host_write(4'd1, 8'h01, 1'b0, 48'h1111, ok);
        host_write(4'd6, 8'h06, 1'b0, 48'h6666, ok2);
        chk("t6_setup_wr", ok & ok2, 1);
        wr_stall = 10;
        pulse_scrub();
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (wr_req && wr_addr == 4'd6) begin ok = 1; break; end
        end
        chk("t6_saw_scr_wr6", ok, 1);
        chk("t6_cleared_before", scrub_cleared, 1);
        repeat (3) @(negedge clk);
        reset = 0; #1;
        chk("t6_rst_wr_req", wr_req, 0);
        chk("t6_rst_rd_req", rd_req, 0);
        chk("t6_rst_wr_addr", wr_addr, 0);
        chk("t6_rst_wr_oq", wr_oq, 0);
        chk("t6_rst_rd_addr", rd_addr, 0);
        chk("t6_rst_busy", scrub_busy, 0);
        chk("t6_rst_cleared", scrub_cleared, 0);
        chk("t6_rst_host_acks", {host_rd_ack, host_wr_ack}, 0);
        repeat (2) @(negedge clk);
        reset = 1; wr_stall = 0; any_req = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (rd_req || wr_req || scrub_busy) any_req = 1;
        end
        chk("t6_idle_after_release", any_req, 0);
        chk("t6_cleared_after", scrub_cleared, 0);
        host_read(4'd6, q_oq, q_pr, q_mac, ok);
        chk("t6_entry6_untouched", q_oq, 8'h06);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
